sram_like_arbiter: RTL and testbench

//  Shares one sram-like memory port between the instruction-fetch master and the data-access master.

---
 rtl/sram_like_arbiter_pkg.sv | 39 +++
 rtl/sram_like_arbiter_if.sv | 26 ++
 rtl/sram_like_arbiter.sv | 123 ++++++++++++
 tb/tb_sram_like_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared types and constants for the sram-like two-master arbiter.
//   arb_state_e : FSM states (idle / address phase / data phase)
//   owner_e     : which master holds, or last held, the bus
//   sram_cmd_t  : request fields carried from a master to the bus
//   SIZE_*      : transfer size encodings used on every sram-like port
//   data_wins   : the arbitration decision taken in IDLE
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_cmd_t;

  // Data has priority unless fetch is waiting and data has already used
  // up its allowed run of consecutive grants.
  function automatic logic data_wins(input logic data_req,
                                     input logic inst_req,
                                     input logic streak_full);
    return data_req && (!inst_req || !streak_full);
  endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One sram-like port: request fields flow master -> slave, read data and
// the two handshake strobes flow slave -> master.
//   req/wr/size/addr/wdata : request, held by the master until addr_ok
//   rdata                  : read data, valid with data_ok
//   addr_ok                : address accepted this cycle
//   data_ok                : data returned / write completed this cycle
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between the instruction-fetch master and
// the data-access master, with at most one transaction outstanding. Data
// has priority, limited by a streak counter so fetch is never starved.
// Ports:
//   clk   : rising-edge clock
//   rstn  : synchronous active-low reset
//   inst  : fetch master port (arbiter is the slave)
//   data  : data master port (arbiter is the slave)
//   bus   : port to the bus bridge (arbiter is the master)
//   owner : current/last grant, 0 = inst, 1 = data
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic                        clk,
  input  logic                        rstn,
  sram_like_arbiter_if.slave          inst,
  sram_like_arbiter_if.slave          data,
  sram_like_arbiter_if.master         bus,
  output logic                        owner
);

  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DATA_STREAK);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] streak_q, streak_d;

  sram_cmd_t inst_cmd;
  sram_cmd_t data_cmd;
  sram_cmd_t bus_cmd;
  logic      sel_data;
  logic      bus_req_c;
  logic      addr_ok_c;
  logic      data_ok_c;
  logic      streak_full;

  assign inst_cmd    = '{wr: inst.wr, size: inst.size, addr: inst.addr, wdata: inst.wdata};
  assign data_cmd    = '{wr: data.wr, size: data.size, addr: data.addr, wdata: data.wdata};
  assign streak_full = (streak_q >= STREAK_MAX);

  // In IDLE the winner is picked combinationally so the bus sees the request
  // in the same cycle; in ADDR/DATA the latched owner steers everything.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    streak_d  = streak_q;
    sel_data  = (owner_q == OWNER_DATA);
    bus_req_c = 1'b0;
    addr_ok_c = 1'b0;
    data_ok_c = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (inst.req || data.req) begin
          sel_data  = data_wins(data.req, inst.req, streak_full);
          bus_req_c = 1'b1;
          owner_d   = sel_data ? OWNER_DATA : OWNER_INST;
          if (sel_data && inst.req) begin
            streak_d = streak_full ? streak_q : streak_q + CNT_W'(1);
          end else begin
            streak_d = '0;
          end
          if (bus.addr_ok) begin
            addr_ok_c = 1'b1;
            state_d   = ARB_DATA;
          end else begin
            state_d   = ARB_ADDR;
          end
        end
      end
      ARB_ADDR: begin
        bus_req_c = 1'b1;
        if (bus.addr_ok) begin
          addr_ok_c = 1'b1;
          state_d   = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (bus.data_ok) begin
          data_ok_c = 1'b1;
          state_d   = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWNER_INST;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  assign bus_cmd   = sel_data ? data_cmd : inst_cmd;
  assign bus.req   = bus_req_c;
  assign bus.wr    = bus_cmd.wr;
  assign bus.size  = bus_cmd.size;
  assign bus.addr  = bus_cmd.addr;
  assign bus.wdata = bus_cmd.wdata;

  // Handshakes are routed only to the selected master.
  assign inst.addr_ok = addr_ok_c & ~sel_data;
  assign data.addr_ok = addr_ok_c &  sel_data;
  assign inst.data_ok = data_ok_c & ~sel_data;
  assign data.data_ok = data_ok_c &  sel_data;

  assign inst.rdata = bus.rdata;
  assign data.rdata = bus.rdata;

  assign owner = (owner_q == OWNER_DATA);

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  localparam int MAX = 4;

  logic clk;
  logic rstn;
  logic owner;

  sram_like_arbiter_if inst_if ();
  sram_like_arbiter_if data_if ();
  sram_like_arbiter_if bus_if ();

  sram_like_arbiter #(.MAX_DATA_STREAK(MAX), .CNT_W(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .inst (inst_if),
    .data (data_if),
    .bus  (bus_if),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: transaction-level view of the shared port.
  bit m_valid = 0;
  bit m_busy = 0;
  bit m_addr_done = 0;
  bit m_owner = 0;
  int m_streak = 0;

  always @(negedge clk) begin
    bit e_breq, e_aok, e_dok, sel, grant;
    logic [66:0] e_cmd;
    e_breq = 0; e_aok = 0; e_dok = 0; grant = 0;
    sel = m_owner;
    if (!m_busy) begin
      if (inst_if.req || data_if.req) begin
        sel    = data_if.req && (!inst_if.req || m_streak < MAX);
        grant  = 1;
        e_breq = 1;
        e_aok  = bus_if.addr_ok;
      end
    end else if (!m_addr_done) begin
      e_breq = 1;
      e_aok  = bus_if.addr_ok;
    end else begin
      e_dok = bus_if.data_ok;
    end
    e_cmd = sel ? {data_if.wr, data_if.size, data_if.addr, data_if.wdata}
                : {inst_if.wr, inst_if.size, inst_if.addr, inst_if.wdata};

    if (m_valid) begin
      chk("bus_req",      67'(bus_if.req),      67'(e_breq));
      chk("inst_addr_ok", 67'(inst_if.addr_ok), 67'(e_aok && !sel));
      chk("data_addr_ok", 67'(data_if.addr_ok), 67'(e_aok && sel));
      chk("inst_data_ok", 67'(inst_if.data_ok), 67'(e_dok && !sel));
      chk("data_data_ok", 67'(data_if.data_ok), 67'(e_dok && sel));
      chk("owner",        67'(owner),           67'(m_owner));
      chk("inst_rdata",   67'(inst_if.rdata),   67'(bus_if.rdata));
      chk("data_rdata",   67'(data_if.rdata),   67'(bus_if.rdata));
      if (e_breq)
        chk("bus_cmd", {bus_if.wr, bus_if.size, bus_if.addr, bus_if.wdata}, e_cmd);
    end

    if (!rstn) begin
      m_busy = 0; m_addr_done = 0; m_owner = 0; m_streak = 0; m_valid = 1;
    end else if (m_valid) begin
      if (grant) begin
        m_owner = sel;
        if (sel && inst_if.req) m_streak = (m_streak + 1 > MAX) ? MAX : m_streak + 1;
        else m_streak = 0;
        m_busy = 1;
        m_addr_done = bus_if.addr_ok;
      end else if (m_busy && !m_addr_done) begin
        if (bus_if.addr_ok) m_addr_done = 1;
      end else if (m_busy && bus_if.data_ok) begin
        m_busy = 0; m_addr_done = 0;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
    bus_if.rdata = $urandom;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic all_idle();
    inst_if.req = 0; inst_if.wr = 0; inst_if.size = SIZE_WORD; inst_if.addr = '0; inst_if.wdata = '0;
    data_if.req = 0; data_if.wr = 0; data_if.size = SIZE_WORD; data_if.addr = '0; data_if.wdata = '0;
    bus_if.addr_ok = 0; bus_if.data_ok = 0;
  endtask

  logic [9:0] gseq;
  int ng;
  bit i_acc, d_acc;

  initial begin
    rstn = 0;
    all_idle();
    bus_if.rdata = 32'h1234_5678;
    nxt(); nxt();
    rstn = 1;

    // 1: single data read, addr_ok immediately, data_ok two cycles later
    data_if.req = 1; data_if.addr = 32'h10; bus_if.addr_ok = 1;
    smp();
    chk("t1_data_addr_ok", 67'(data_if.addr_ok), 67'd1);
    chk("t1_inst_addr_ok", 67'(inst_if.addr_ok), 67'd0);
    chk("t1_bus_addr",     67'(bus_if.addr),     67'h10);
    nxt();
    data_if.req = 0; bus_if.addr_ok = 0;
    smp();
    chk("t1_data_ok_t1",   67'(data_if.data_ok), 67'd0);
    nxt();
    bus_if.data_ok = 1;
    smp();
    chk("t1_data_ok_t2",   67'(data_if.data_ok), 67'd1);
    chk("t1_inst_ok_t2",   67'(inst_if.data_ok), 67'd0);
    nxt();
    all_idle();

    // 2: both masters requesting continuously with immediate acks
    inst_if.req = 1; inst_if.addr = 32'h100;
    data_if.req = 1; data_if.addr = 32'h200;
    bus_if.addr_ok = 1; bus_if.data_ok = 1;
    gseq = '0; ng = 0;
    for (int c = 0; c < 20; c++) begin
      smp();
      if (inst_if.addr_ok || data_if.addr_ok) begin
        gseq = {gseq[8:0], data_if.addr_ok};
        ng++;
      end
      nxt();
    end
    chk("t2_grant_count", 67'(ng),   67'd10);
    chk("t2_grant_order", 67'(gseq), 67'b1111011110);
    all_idle();

    // 3: delayed addr_ok; data drops req while inst rises, bus stays on data
    data_if.req = 1; data_if.addr = 32'hA0;
    smp();
    nxt();
    data_if.req = 0; inst_if.req = 1; inst_if.addr = 32'hB0;
    for (int c = 0; c < 3; c++) begin
      smp();
      chk("t3_bus_req",      67'(bus_if.req),      67'd1);
      chk("t3_owner",        67'(owner),           67'd1);
      chk("t3_bus_addr",     67'(bus_if.addr),     67'hA0);
      chk("t3_inst_addr_ok", 67'(inst_if.addr_ok), 67'd0);
      nxt();
    end
    bus_if.addr_ok = 1;
    smp();
    chk("t3_data_addr_ok", 67'(data_if.addr_ok), 67'd1);
    nxt();
    bus_if.addr_ok = 0; bus_if.data_ok = 1;
    smp();
    chk("t3_data_data_ok", 67'(data_if.data_ok), 67'd1);
    nxt();
    bus_if.data_ok = 0; bus_if.addr_ok = 1;
    smp();
    chk("t3_inst_addr_ok2", 67'(inst_if.addr_ok), 67'd1);
    chk("t3_bus_addr2",     67'(bus_if.addr),     67'hB0);
    nxt();
    inst_if.req = 0; bus_if.addr_ok = 0; bus_if.data_ok = 1;
    smp();
    nxt();
    all_idle();

    // 4: reset while waiting for data_ok; late data_ok must be dropped
    data_if.req = 1; data_if.addr = 32'hC0; bus_if.addr_ok = 1;
    smp();
    nxt();
    data_if.req = 0; bus_if.addr_ok = 0; rstn = 0;
    smp();
    nxt();
    rstn = 1; bus_if.data_ok = 1;
    smp();
    chk("t4_bus_req",      67'(bus_if.req),      67'd0);
    chk("t4_owner",        67'(owner),           67'd0);
    chk("t4_data_data_ok", 67'(data_if.data_ok), 67'd0);
    chk("t4_inst_data_ok", 67'(inst_if.data_ok), 67'd0);
    nxt();

    // 5: spurious data_ok in IDLE, then a request is granted at once
    smp();
    chk("t5_data_data_ok", 67'(data_if.data_ok), 67'd0);
    chk("t5_inst_data_ok", 67'(inst_if.data_ok), 67'd0);
    nxt();
    bus_if.data_ok = 0; data_if.req = 1; data_if.addr = 32'hD0; bus_if.addr_ok = 1;
    smp();
    chk("t5_data_addr_ok", 67'(data_if.addr_ok), 67'd1);
    nxt();
    data_if.req = 0; bus_if.addr_ok = 0; bus_if.data_ok = 1;
    smp();
    nxt();
    all_idle();

    // 6: fetch-side write forwarded unchanged
    inst_if.req = 1; inst_if.wr = 1; inst_if.size = SIZE_HALF;
    inst_if.addr = 32'h2; inst_if.wdata = 32'hDEAD_BEEF;
    smp();
    chk("t6_bus_wr",    67'(bus_if.wr),    67'd1);
    chk("t6_bus_size",  67'(bus_if.size),  67'b01);
    chk("t6_bus_addr",  67'(bus_if.addr),  67'h2);
    chk("t6_bus_wdata", 67'(bus_if.wdata), 67'hDEAD_BEEF);
    nxt();
    bus_if.addr_ok = 1;
    smp();
    chk("t6_inst_addr_ok", 67'(inst_if.addr_ok), 67'd1);
    nxt();
    inst_if.req = 0; inst_if.wr = 0; bus_if.addr_ok = 0; bus_if.data_ok = 1;
    smp();
    chk("t6_inst_data_ok", 67'(inst_if.data_ok), 67'd1);
    nxt();
    all_idle();

    // Random traffic: masters obey the hold-until-addr_ok rule, the bus
    // acknowledges at random, and reset is occasionally pulsed.
    for (int c = 0; c < 3000; c++) begin
      smp();
      i_acc = inst_if.addr_ok;
      d_acc = data_if.addr_ok;
      nxt();
      if (!inst_if.req || i_acc) begin
        inst_if.req   = ($urandom % 3) != 0;
        inst_if.wr    = ($urandom % 8) == 0;
        inst_if.size  = 2'($urandom % 3);
        inst_if.addr  = $urandom;
        inst_if.wdata = $urandom;
      end
      if (!data_if.req || d_acc) begin
        data_if.req   = ($urandom % 3) != 0;
        data_if.wr    = $urandom % 2;
        data_if.size  = 2'($urandom % 3);
        data_if.addr  = $urandom;
        data_if.wdata = $urandom;
      end
      bus_if.addr_ok = ($urandom % 2) == 0;
      bus_if.data_ok = ($urandom % 5) < 2;
      rstn = ($urandom % 150) != 0;
      if (!rstn) begin
        inst_if.req = 0;
        data_if.req = 0;
      end
    end
    smp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
